// File: rtl/inv_sub_bytes.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : inv_sub_bytes                                              |
// | Description : AES InvSubBytes engine. Latches a 128-bit state, then      |
// |               substitutes WORDS_PER_CYCLE 32-bit words per cycle through |
// |               the FIPS-197 inverse S-box (word 0 first). Valid/ready     |
// |               handshake on both sides.                                   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
// | Ports                                                                    |
// |   clk        in   1    rising-edge clock                                 |
// |   rst_n      in   1    asynchronous active-low reset                     |
// |   fwd        in   1    (optional) 1 = forward S-box, 0 = inverse         |
// |   in_valid   in   1    state_in valid                                    |
// |   in_ready   out  1    ready to accept a state (IDLE)                    |
// |   state_in   in   128  input state, word k = [32k+31:32k]                |
// |   out_valid  out  1    state_out holds a finished result (DONE)          |
// |   out_ready  in   1    downstream accepts state_out                      |
// |   state_out  out  128  substituted state, same layout                    |
// |   busy       out  1    substitution in progress (RUN)                    |
// | Macro                                                                    |
// |   INV_SUB_BYTES_FWD_MODE_EN : adds the fwd port and the forward S-box.   |
// +--------------------------------------------------------------------------+
module inv_sub_bytes #(
  parameter int WORDS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
`ifdef INV_SUB_BYTES_FWD_MODE_EN
  input  logic         fwd,
`endif
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out,
  output logic         busy
);

  if (!(WORDS_PER_CYCLE == 1 || WORDS_PER_CYCLE == 2 || WORDS_PER_CYCLE == 4)) begin : g_param_check
    $error("inv_sub_bytes: WORDS_PER_CYCLE must be 1, 2 or 4");
  end

  localparam logic [1:0] C_LAST_CNT = 2'(4 - WORDS_PER_CYCLE);
  localparam logic [1:0] C_CNT_STEP = 2'(WORDS_PER_CYCLE);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = 8'h00;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = sh[7] ? ({sh[6:0], 1'b0} ^ 8'h1b) : {sh[6:0], 1'b0};
    end
    return acc;
  endfunction

  // Multiplicative inverse as x^254; maps 0 to 0 as AES requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = x;
    for (int i = 0; i < 8; i++) begin
      if (i != 0) r = gf_mul(r, p);  // 254 = 0b11111110
      p = gf_mul(p, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
    logic [15:0] t;
    t = {b, b} << k;
    return t[15:8];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] y);
    logic [7:0] a;
    a = rotl8(y, 1) ^ rotl8(y, 3) ^ rotl8(y, 6) ^ 8'h05;
    return gf_inv(a);
  endfunction

`ifdef INV_SUB_BYTES_FWD_MODE_EN
  function automatic logic [7:0] fwd_sbox(input logic [7:0] x);
    logic [7:0] b;
    b = gf_inv(x);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction
`endif

  state_e         state_q, state_d;
  logic [1:0]     cnt_q, cnt_d;
  logic [127:0]   in_state_q, in_state_d;
  logic [127:0]   out_state_q, out_state_d;
`ifdef INV_SUB_BYTES_FWD_MODE_EN
  logic           fwd_q, fwd_d;
`endif

  logic [31:0]    w_sub [WORDS_PER_CYCLE];

  // One substitution lane per word handled in a cycle; lane l works on
  // word cnt+l of the latched state.
  for (genvar l = 0; l < WORDS_PER_CYCLE; l++) begin : g_lane
    logic [1:0]  w_idx;
    logic [31:0] w_src;
    logic [31:0] w_res;
    assign w_idx = cnt_q + 2'(l);
    assign w_src = in_state_q[{w_idx, 5'd0} +: 32];
    for (genvar b = 0; b < 4; b++) begin : g_byte
`ifdef INV_SUB_BYTES_FWD_MODE_EN
      assign w_res[8*b +: 8] = fwd_q ? fwd_sbox(w_src[8*b +: 8]) : inv_sbox(w_src[8*b +: 8]);
`else
      assign w_res[8*b +: 8] = inv_sbox(w_src[8*b +: 8]);
`endif
    end
    assign w_sub[l] = w_res;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    in_state_d  = in_state_q;
    out_state_d = out_state_q;
`ifdef INV_SUB_BYTES_FWD_MODE_EN
    fwd_d       = fwd_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          in_state_d = state_in;
`ifdef INV_SUB_BYTES_FWD_MODE_EN
          fwd_d      = fwd;
`endif
          cnt_d      = 2'd0;
          state_d    = RUN;
        end
      end
      RUN: begin
        for (int l = 0; l < WORDS_PER_CYCLE; l++) begin
          out_state_d[{cnt_q + 2'(l), 5'd0} +: 32] = w_sub[l];
        end
        if (cnt_q == C_LAST_CNT) begin
          cnt_d   = 2'd0;
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q + C_CNT_STEP;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 2'd0;
      in_state_q  <= '0;
      out_state_q <= '0;
`ifdef INV_SUB_BYTES_FWD_MODE_EN
      fwd_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      in_state_q  <= in_state_d;
      out_state_q <= out_state_d;
`ifdef INV_SUB_BYTES_FWD_MODE_EN
      fwd_q       <= fwd_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == RUN);
  assign out_valid = (state_q == DONE);
  assign state_out = out_state_q;

endmodule
`default_nettype wire
